// File: rtl/demux_collect.sv
// Registered 1-to-depth demultiplexer and bit collector: steers a serial bit stream
// into a depth-bit word and hands each complete word downstream with valid/ready.
module demux_collect #(
  parameter int width = 2,
  parameter int depth = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic [width-1:0] sel,
  input  logic             auto,
  input  logic             clear,
  output logic [depth-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [width-1:0] ptr,
  output logic             err
);

  // state   | meaning
  // COLLECT | word being assembled, out_valid low
  // HOLD    | complete word presented, frozen until out_ready
  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_e;

  localparam logic [width-1:0] PTR_LAST = width'(depth - 1);

  state_e           state_q, state_d;
  logic [depth-1:0] out_q, out_d;
  logic [depth-1:0] wr_mask_q, wr_mask_d;
  logic [width-1:0] ptr_q, ptr_d;
  logic             err_q, err_d;

  logic [width-1:0] pos;
  logic [depth-1:0] hit;
  logic [depth-1:0] mask_next;
  logic             accept;

  assign din_ready = (state_q == COLLECT) || out_ready;
  assign accept    = din_valid && din_ready && !clear;
  assign pos       = auto ? ptr_q : sel;
  assign mask_next = wr_mask_q | hit;

  // One-hot target; all-zero when pos falls outside the word.
  always_comb begin
    hit = '0;
    for (int i = 0; i < depth; i++) begin
      hit[i] = (pos == width'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    out_d     = out_q;
    wr_mask_d = wr_mask_q;
    ptr_d     = ptr_q;
    err_d     = err_q;

    if (clear) begin
      state_d   = COLLECT;
      out_d     = '0;
      wr_mask_d = '0;
      ptr_d     = '0;
      err_d     = 1'b0;
    end else begin
      if (state_q == HOLD && out_ready) begin
        state_d = COLLECT;
      end
      // A write accepted during the handshake cycle lands in the fresh word;
      // wr_mask is already empty there, so it can never complete it.
      if (accept) begin
        if (hit == '0) begin
          err_d = 1'b1;
        end else begin
          out_d = (out_q & ~hit) | (hit & {depth{din}});
          if ((wr_mask_q & hit) != '0) begin
            err_d = 1'b1;
          end
          if (auto) begin
            ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + width'(1);
          end
          if (&mask_next) begin
            state_d   = HOLD;
            wr_mask_d = '0;
            ptr_d     = '0;
          end else begin
            wr_mask_d = mask_next;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= COLLECT;
      out_q     <= '0;
      wr_mask_q <= '0;
      ptr_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      out_q     <= out_d;
      wr_mask_q <= wr_mask_d;
      ptr_q     <= ptr_d;
      err_q     <= err_d;
    end
  end

  assign out       = out_q;
  assign out_valid = (state_q == HOLD);
  assign ptr       = ptr_q;
  assign err       = err_q;

endmodule

// File: tb/tb_demux_collect.sv
// Bench for demux_collect: directed checks on default and 16-bit instances, plus a
// randomized run on a 5-bit instance scored against a behavioural word model.
module tb_demux_collect;

  logic clk;
  logic rst_n;

  // Instance A: default width=2, depth=4
  logic       a_din, a_din_valid, a_din_ready, a_auto, a_clear;
  logic       a_out_valid, a_out_ready, a_err;
  logic [1:0] a_sel, a_ptr;
  logic [3:0] a_out;

  // Instance B: width=3, depth=5 (out-of-range sel reachable)
  logic       b_din, b_din_valid, b_din_ready, b_auto, b_clear;
  logic       b_out_valid, b_out_ready, b_err;
  logic [2:0] b_sel, b_ptr;
  logic [4:0] b_out;

  // Instance C: width=4, depth=16
  logic        c_din, c_din_valid, c_din_ready, c_auto, c_clear;
  logic        c_out_valid, c_out_ready, c_err;
  logic [3:0]  c_sel, c_ptr;
  logic [15:0] c_out;

  demux_collect u_a (
    .clk(clk), .rst_n(rst_n), .din(a_din), .din_valid(a_din_valid), .din_ready(a_din_ready),
    .sel(a_sel), .auto(a_auto), .clear(a_clear), .out(a_out), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .ptr(a_ptr), .err(a_err)
  );

  demux_collect #(.width(3), .depth(5)) u_b (
    .clk(clk), .rst_n(rst_n), .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
    .sel(b_sel), .auto(b_auto), .clear(b_clear), .out(b_out), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .ptr(b_ptr), .err(b_err)
  );

  demux_collect #(.width(4), .depth(16)) u_c (
    .clk(clk), .rst_n(rst_n), .din(c_din), .din_valid(c_din_valid), .din_ready(c_din_ready),
    .sel(c_sel), .auto(c_auto), .clear(c_clear), .out(c_out), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .ptr(c_ptr), .err(c_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic a_drive(input logic d, input logic v, input logic au, input logic [1:0] s,
                         input logic cl, input logic ro);
    a_din = d; a_din_valid = v; a_auto = au; a_sel = s; a_clear = cl; a_out_ready = ro;
  endtask

  task automatic c_drive(input logic d, input logic v, input logic au, input logic [3:0] s,
                         input logic cl, input logic ro);
    c_din = d; c_din_valid = v; c_auto = au; c_sel = s; c_clear = cl; c_out_ready = ro;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for instance B: expected words queued by the model, popped by the monitor
  typedef struct {
    logic [4:0] word;
    logic       err;
  } exp_t;
  exp_t exp_q[$];

  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (b_out_valid === 1'b1 && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("b_unexpected_word", 32'(b_out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("b_word", 32'(b_out), 32'(e.word));
          check("b_word_err", 32'(b_err), 32'(e.err));
        end
      end
      prev_v = (b_out_valid === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [3:0]  bits;
    logic [15:0] cword;
    int          sa[4];
    int          da[4];
    // behavioural model of instance B
    logic [4:0]  m_word, m_written;
    int          m_ptr, p;
    logic        m_hold, m_err, m_ready;

    rst_n = 1'b0;
    a_drive(0, 0, 0, 2'd0, 0, 0);
    c_drive(0, 0, 0, 4'd0, 0, 0);
    b_din = 0; b_din_valid = 0; b_auto = 0; b_sel = 0; b_clear = 0; b_out_ready = 0;
    #3;
    check("rst_out", 32'(a_out), 32'd0);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_ptr", 32'(a_ptr), 32'd0);
    check("rst_err", 32'(a_err), 32'd0);
    check("rst_din_ready", 32'(a_din_ready), 32'd1);
    #10 rst_n = 1'b1;
    tick();

    // Auto fill 1,0,1,1
    bits = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      a_drive(bits[i], 1, 1, 2'd0, 0, 1);
      tick();
      if (i < 3) check("auto_not_yet_valid", 32'(a_out_valid), 32'd0);
    end
    check("auto_out", 32'(a_out), 32'(4'b1101));
    check("auto_out_valid", 32'(a_out_valid), 32'd1);
    check("auto_ptr_wrap", 32'(a_ptr), 32'd0);
    a_drive(0, 1, 1, 2'd0, 0, 1);
    #1 check("auto_handshake_ready", 32'(a_din_ready), 32'd1);
    tick();
    check("auto_valid_one_cycle", 32'(a_out_valid), 32'd0);
    check("auto_next_word_ptr", 32'(a_ptr), 32'd1);
    check("auto_next_word_bit0", 32'(a_out[0]), 32'd0);
    a_drive(0, 0, 0, 2'd0, 1, 1);
    tick();
    check("clear_out", 32'(a_out), 32'd0);

    // Addressed fill sel=3,0,2,1 din=1,1,0,0
    sa = '{3, 0, 2, 1};
    da = '{1, 1, 0, 0};
    for (int i = 0; i < 4; i++) begin
      a_drive(da[i][0], 1, 0, 2'(sa[i]), 0, 1);
      tick();
    end
    check("addr_out", 32'(a_out), 32'(4'b1001));
    check("addr_out_valid", 32'(a_out_valid), 32'd1);
    check("addr_err", 32'(a_err), 32'd0);
    a_drive(0, 0, 0, 2'd0, 1, 1);
    tick();
    a_drive(0, 1, 0, 2'd3, 0, 1);
    tick();
    check("dup_first_no_err", 32'(a_err), 32'd0);
    a_drive(1, 1, 0, 2'd3, 0, 1);
    tick();
    check("dup_err", 32'(a_err), 32'd1);
    check("dup_second_wins", 32'(a_out[3]), 32'd1);
    check("dup_ptr_static", 32'(a_ptr), 32'd0);

    // Backpressure
    a_drive(0, 0, 0, 2'd0, 1, 0);
    tick();
    bits = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      a_drive(bits[i], 1, 1, 2'd0, 0, 0);
      tick();
    end
    check("bp_out_valid", 32'(a_out_valid), 32'd1);
    check("bp_out", 32'(a_out), 32'(4'b0110));
    for (int i = 0; i < 3; i++) begin
      a_drive(1, 1, 1, 2'd0, 0, 0);
      #1 check("bp_din_ready_low", 32'(a_din_ready), 32'd0);
      tick();
      check("bp_out_stable", 32'(a_out), 32'(4'b0110));
      check("bp_ptr_held", 32'(a_ptr), 32'd0);
    end
    a_drive(1, 1, 1, 2'd0, 0, 1);
    #1 check("bp_release_ready", 32'(a_din_ready), 32'd1);
    tick();
    check("bp_valid_falls", 32'(a_out_valid), 32'd0);
    check("bp_bit_to_next_word", 32'(a_out[0]), 32'd1);
    check("bp_ptr_next", 32'(a_ptr), 32'd1);

    // Clear after two auto writes, with a concurrent din
    a_drive(0, 0, 0, 2'd0, 1, 1);
    tick();
    a_drive(1, 1, 0, 2'd0, 0, 1);
    tick();
    tick();
    check("pre_clear_err", 32'(a_err), 32'd1);
    a_drive(1, 1, 1, 2'd0, 0, 1);
    tick();
    tick();
    check("pre_clear_ptr", 32'(a_ptr), 32'd2);
    a_drive(1, 1, 1, 2'd0, 1, 1);
    tick();
    check("clear_out_zero", 32'(a_out), 32'd0);
    check("clear_ptr_zero", 32'(a_ptr), 32'd0);
    check("clear_err_zero", 32'(a_err), 32'd0);
    bits = 4'b0101;
    for (int i = 0; i < 4; i++) begin
      a_drive(bits[i], 1, 1, 2'd0, 0, 1);
      tick();
      if (i == 2) check("clear_needs_four", 32'(a_out_valid), 32'd0);
    end
    check("clear_word_valid", 32'(a_out_valid), 32'd1);
    check("clear_word_out", 32'(a_out), 32'(4'b0101));

    // Asynchronous reset mid-word, then during HOLD
    a_drive(0, 0, 0, 2'd0, 1, 1);
    tick();
    a_drive(1, 1, 1, 2'd0, 0, 1);
    tick();
    tick();
    a_drive(0, 0, 0, 2'd0, 0, 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_mid_out", 32'(a_out), 32'd0);
    check("arst_mid_ptr", 32'(a_ptr), 32'd0);
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      a_drive(1, 1, 1, 2'd0, 0, 0);
      tick();
    end
    check("arst_hold_entered", 32'(a_out_valid), 32'd1);
    a_drive(0, 0, 0, 2'd0, 0, 0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_hold_valid", 32'(a_out_valid), 32'd0);
    check("arst_hold_out", 32'(a_out), 32'd0);
    check("arst_hold_din_ready", 32'(a_din_ready), 32'd1);
    #2 rst_n = 1'b1;
    tick();

    // 16-bit instance
    cword = 16'hA5C3;
    for (int i = 0; i < 16; i++) begin
      c_drive(cword[i], 1, 1, 4'd0, 0, 1);
      tick();
      if (i == 14) check("c_not_yet_valid", 32'(c_out_valid), 32'd0);
    end
    check("c_auto_out", 32'(c_out), 32'(16'hA5C3));
    check("c_auto_valid", 32'(c_out_valid), 32'd1);
    check("c_auto_ptr", 32'(c_ptr), 32'd0);
    c_drive(0, 1, 0, 4'd15, 0, 1);
    tick();
    check("c_sel15_out", 32'(c_out), 32'(16'h25C3));
    check("c_sel15_valid", 32'(c_out_valid), 32'd0);
    check("c_sel15_err", 32'(c_err), 32'd0);
    c_drive(0, 0, 0, 4'd0, 0, 0);

    // Randomized run on instance B
    m_word = '0; m_written = '0; m_ptr = 0; m_hold = 1'b0; m_err = 1'b0;
    b_auto = 1'b1;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      b_din       = 1'($urandom_range(0, 1));
      b_din_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) b_auto = ~b_auto;
      b_sel       = ($urandom_range(0, 15) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      b_clear     = ($urandom_range(0, 59) == 0);
      b_out_ready = ($urandom_range(0, 2) != 0);
      m_ready = !m_hold || b_out_ready;
      #1 check("b_din_ready", 32'(b_din_ready), 32'(m_ready));
      @(posedge clk);
      if (b_clear) begin
        m_word = '0; m_written = '0; m_ptr = 0; m_hold = 1'b0; m_err = 1'b0;
      end else begin
        if (m_hold && b_out_ready) m_hold = 1'b0;
        if (b_din_valid && m_ready) begin
          p = b_auto ? m_ptr : int'(b_sel);
          if (p >= 5) begin
            m_err = 1'b1;
          end else begin
            if (m_written[p]) m_err = 1'b1;
            m_word[p]    = b_din;
            m_written[p] = 1'b1;
            if (b_auto) m_ptr = (m_ptr + 1) % 5;
            if (m_written == 5'b11111) begin
              m_hold    = 1'b1;
              m_written = '0;
              m_ptr     = 0;
              exp_q.push_back('{m_word, m_err});
            end
          end
        end
      end
      #1;
    end
    b_din_valid = 1'b0;
    b_clear     = 1'b0;
    check("b_final_ptr", 32'(b_ptr), 32'(m_ptr));
    check("b_final_err", 32'(b_err), 32'(m_err));
    check("b_final_valid", 32'(b_out_valid), 32'(m_hold));
    @(negedge clk);
    @(negedge clk);
    #1;
    check("b_queue_drained", 32'(exp_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux_collect.md
# demux_collect

Registered 1-to-`depth` demultiplexer and bit collector, the write-side counterpart of the team's `in[sel]` bit-select mux. It steers a serial bit stream into a `depth`-bit word, either at an explicit `sel` position or at an auto-incrementing pointer. When every position of the word has been written, it presents the word to a downstream consumer with a valid/ready handshake. It sits between a bit-serial producer and any block that consumes parallel `depth`-bit vectors, such as a mux instance's `in` bus.

## Interface
- `width`, default 2: select/pointer width in bits.
- `depth`, default 4: word length in bits. Legal range is 2 <= `depth` <= 2**`width`.

- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `din`  input  1  serial data bit.
- `din_valid`  input  1  `din` is offered this cycle.
- `din_ready`  output  1  block can accept `din`. Combinational: `!out_valid || out_ready`.
- `sel`  input  `width`  target bit position when `auto`=0.
- `auto`  input  1  1 = write at `ptr`; 0 = write at `sel`.
- `clear`  input  1  synchronous abort of the current word.
- `out`  output  `depth`  collected word.
- `out_valid`  output  1  `out` holds a complete word.
- `out_ready`  input  1  consumer accepts `out` this cycle.
- `ptr`  output  `width`  auto-mode write pointer.
- `err`  output  1  sticky error flag.

## Operation
- Internal `wr_mask[depth-1:0]` records the positions written in the current word.
- A write is accepted when `din_valid && din_ready && !clear`.
- Target position `pos` is `ptr` if `auto`=1, otherwise `sel`.
- On an accepted write with `pos` < `depth`:
  - `out[pos]` <= `din`; `wr_mask[pos]` <= 1.
  - If `auto`=1, `ptr` <= (`ptr`==`depth`-1) ? 0 : `ptr`+1.
  - If `wr_mask[pos]` was already 1, the bit is overwritten and `err` <= 1.
- `sel` >= `depth` with `auto`=0: the write is accepted but discarded. `out`, `wr_mask` and `ptr` are unchanged, and `err` <= 1.
- Completion: when an accepted write makes `wr_mask` all-ones, the same edge sets `out_valid` <= 1, `wr_mask` <= 0 and `ptr` <= 0.
- Two states:
  - COLLECT (`out_valid`=0). Goes to HOLD on completion.
  - HOLD (`out_valid`=1). `out` is frozen unless `out_ready`=1. On `out_ready`=1 the state goes to COLLECT at the next edge. If a write is accepted in that same cycle, it lands in the new word; because `depth` >= 2 it cannot complete the new word.
- HOLD with `out_ready`=0: `din_ready`=0, no writes, everything held.
- `clear`=1 has priority over everything else. Next edge: `out`=0, `wr_mask`=0, `ptr`=0, `out_valid`=0, `err`=0. A `din` offered in that cycle is dropped, even though `din_ready` may read 1.
- `auto` may change between writes. `ptr` advances only on auto-mode writes.

## Timing
- Reset values (asynchronous, on `rst_n` falling): `out`=0, `out_valid`=0, `ptr`=0, `err`=0, `wr_mask`=0, so `din_ready`=1.
- Reset mid-word or during HOLD discards all state immediately.
- Latency: the bit written at edge N is visible on `out` after edge N.
- On the completing write at edge N, `out_valid` rises after edge N, in the same cycle the last bit appears on `out`.
- Minimum word period in auto mode with `out_ready` tied high is `depth` cycles; back-to-back words need no bubbles.
- `din_ready` depends combinationally on `out_ready`. There are no other combinational input-to-output paths.
- `err` sets one edge after the offending write and holds until `clear` or reset.

## Test plan
- Auto fill with `depth`=4, `out_ready`=1, `din` = 1,0,1,1 on consecutive cycles:
  - after 4th edge: `out`=4'b1101, `out_valid`=1 for one cycle, `ptr`=0.
  - next word starts without a gap.
- Addressed fill with `sel` = 3,0,2,1 and `din` = 1,1,0,0:
  - `out`=4'b1001, `out_valid`=1, `err`=0.
  - `sel`=3,3 in a fresh word instead: `err`=1 and the second value wins.
- Backpressure: complete a word with `out_ready`=0 for 3 cycles while `din_valid`=1.
  - `din_ready`=0, `out` stable, no bits consumed.
  - raise `out_ready`: the word is accepted, the concurrent bit goes to `out[0]` of the next word, `out_valid` falls.
- `clear` asserted after 2 auto writes, together with `din_valid`=1:
  - `out`=0, `ptr`=0, `err`=0; the concurrent bit is dropped.
  - 4 further writes are needed to complete a word.
- `rst_n` pulsed low mid-word and again during HOLD: all outputs return to reset values asynchronously, before the next clock edge.
- Non-default `width`=4, `depth`=16, auto-fill 16'hA5C3, LSB first: `out`=16'hA5C3 after 16 edges. `sel`=4'd15 in addressed mode writes `out[15]`.
